scoreboard_regfile: RTL and testbench

//  Parametrised multi-port register file with write-through bypass and a per-register

---
 rtl/scoreboard_regfile_pkg.sv | 27 ++
 rtl/regfile_bypass_mux.sv | 43 ++++
 rtl/scoreboard_regfile.sv | 99 +++++++++
 tb/tb_scoreboard_regfile.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_regfile_pkg.sv
// rtl/scoreboard_regfile_pkg.sv - shared widths and write-port priority helper
package scoreboard_regfile_pkg;

  localparam int REG_IDX_W  = 4;
  localparam int REG_DATA_W = 32;
  localparam int MAX_WRITE  = 32;
  localparam int PORT_W     = 5;

  typedef struct packed {
    logic              hit;
    logic [PORT_W-1:0] port;
  } wr_hit_t;

  // Scans upward so the highest-numbered matching port is the one reported.
  function automatic wr_hit_t highest_hit(input logic [MAX_WRITE-1:0] match);
    wr_hit_t res;
    res = '0;
    for (int p = 0; p < MAX_WRITE; p++) begin
      if (match[p]) begin
        res.hit  = 1'b1;
        res.port = PORT_W'(p);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// rtl/regfile_bypass_mux.sv - per read port forwarding, ready flag and zero-reg override
module regfile_bypass_mux
  import scoreboard_regfile_pkg::*;
#(
  parameter int INDEX_BIT_WIDTH = REG_IDX_W,
  parameter int DATA_BIT_WIDTH  = REG_DATA_W,
  parameter int N_WRITE         = 2,
  parameter int ZERO_REG_EN     = 1,
  parameter int BYPASS_EN       = 1
) (
  input  logic [INDEX_BIT_WIDTH-1:0]         rd_idx,
  input  logic [DATA_BIT_WIDTH-1:0]          reg_data,
  input  logic                               reg_pending,
  input  logic [N_WRITE-1:0]                 wr_en,
  input  logic [N_WRITE*INDEX_BIT_WIDTH-1:0] wr_idx,
  input  logic [N_WRITE*DATA_BIT_WIDTH-1:0]  wr_data,
  output logic [DATA_BIT_WIDTH-1:0]          rd_data,
  output logic                               rd_ready
);

  logic [N_WRITE-1:0] match;
  wr_hit_t            hit;

  always_comb begin
    match = '0;
    for (int p = 0; p < N_WRITE; p++) begin
      match[p] = wr_en[p] && (wr_idx[p*INDEX_BIT_WIDTH +: INDEX_BIT_WIDTH] == rd_idx);
    end
    hit = highest_hit(MAX_WRITE'(match));

    rd_data  = reg_data;
    rd_ready = ~reg_pending;
    if ((BYPASS_EN != 0) && hit.hit) begin
      rd_data  = wr_data[int'(hit.port)*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
      rd_ready = 1'b1;
    end
    if ((ZERO_REG_EN != 0) && (rd_idx == '0)) begin
      rd_data  = '0;
      rd_ready = 1'b1;
    end
  end

endmodule

// File: rtl/scoreboard_regfile.sv
// rtl/scoreboard_regfile.sv - multi-port register file with bypass and pending scoreboard
module scoreboard_regfile
  import scoreboard_regfile_pkg::*;
#(
  parameter int INDEX_BIT_WIDTH = REG_IDX_W,
  parameter int DATA_BIT_WIDTH  = REG_DATA_W,
  parameter int N_READ          = 2,
  parameter int N_WRITE         = 2,
  parameter int ZERO_REG_EN     = 1,
  parameter int BYPASS_EN       = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_WRITE-1:0]                 wr_en,
  input  logic [N_WRITE*INDEX_BIT_WIDTH-1:0] wr_idx,
  input  logic [N_WRITE*DATA_BIT_WIDTH-1:0]  wr_data,
  input  logic [N_READ*INDEX_BIT_WIDTH-1:0]  rd_idx,
  output logic [N_READ*DATA_BIT_WIDTH-1:0]   rd_data,
  output logic [N_READ-1:0]                  rd_ready,
  input  logic                               rsv_en,
  input  logic [INDEX_BIT_WIDTH-1:0]         rsv_idx,
  output logic                               rsv_stall
);

  localparam int N_REGS = 1 << INDEX_BIT_WIDTH;

  logic [DATA_BIT_WIDTH-1:0] regs [N_REGS];
  logic [N_REGS-1:0]         pending;
  logic [N_REGS-1:0]         pending_nxt;
  logic [N_WRITE-1:0]        wr_en_eff;
  logic [N_WRITE-1:0]        rsv_match;
  logic                      rsv_zero;
  logic                      rsv_ok;
  wr_hit_t                   rsv_hit;

  // Keeps forwarded data off the read ports while reset is held.
  assign wr_en_eff = rst_n ? wr_en : '0;

  always_comb begin
    rsv_match = '0;
    for (int p = 0; p < N_WRITE; p++) begin
      rsv_match[p] = wr_en_eff[p] &&
                     (wr_idx[p*INDEX_BIT_WIDTH +: INDEX_BIT_WIDTH] == rsv_idx);
    end
    rsv_hit   = highest_hit(MAX_WRITE'(rsv_match));
    rsv_zero  = (ZERO_REG_EN != 0) && (rsv_idx == '0);
    rsv_stall = rsv_en && pending[rsv_idx] && !rsv_hit.hit && !rsv_zero;
    rsv_ok    = rsv_en && !rsv_stall && !rsv_zero;
  end

  // Write clears go first so a same-cycle reservation leaves the register pending.
  always_comb begin
    pending_nxt = pending;
    for (int p = 0; p < N_WRITE; p++) begin
      if (wr_en[p]) pending_nxt[wr_idx[p*INDEX_BIT_WIDTH +: INDEX_BIT_WIDTH]] = 1'b0;
    end
    if (rsv_ok) pending_nxt[rsv_idx] = 1'b1;
    if (ZERO_REG_EN != 0) pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      for (int p = 0; p < N_WRITE; p++) begin
        if (wr_en[p] && !((ZERO_REG_EN != 0) &&
                          (wr_idx[p*INDEX_BIT_WIDTH +: INDEX_BIT_WIDTH] == '0))) begin
          regs[wr_idx[p*INDEX_BIT_WIDTH +: INDEX_BIT_WIDTH]] <=
            wr_data[p*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
        end
      end
      pending <= pending_nxt;
    end
  end

  for (genvar r = 0; r < N_READ; r++) begin : g_rd
    logic [INDEX_BIT_WIDTH-1:0] idx;
    assign idx = rd_idx[r*INDEX_BIT_WIDTH +: INDEX_BIT_WIDTH];

    regfile_bypass_mux #(
      .INDEX_BIT_WIDTH (INDEX_BIT_WIDTH),
      .DATA_BIT_WIDTH  (DATA_BIT_WIDTH),
      .N_WRITE         (N_WRITE),
      .ZERO_REG_EN     (ZERO_REG_EN),
      .BYPASS_EN       (BYPASS_EN)
    ) u_mux (
      .rd_idx      (idx),
      .reg_data    (regs[idx]),
      .reg_pending (pending[idx]),
      .wr_en       (wr_en_eff),
      .wr_idx      (wr_idx),
      .wr_data     (wr_data),
      .rd_data     (rd_data[r*DATA_BIT_WIDTH +: DATA_BIT_WIDTH]),
      .rd_ready    (rd_ready[r])
    );
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// tb/tb_scoreboard_regfile.sv - directed self-checking bench for scoreboard_regfile
module tb_scoreboard_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wr_en;
  logic [7:0]  wr_idx;
  logic [63:0] wr_data;
  logic [7:0]  rd_idx;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic        rsv_en;
  logic [3:0]  rsv_idx;
  logic        rsv_stall;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  scoreboard_regfile #(
    .INDEX_BIT_WIDTH (4),
    .DATA_BIT_WIDTH  (32),
    .N_READ          (2),
    .N_WRITE         (2),
    .ZERO_REG_EN     (1),
    .BYPASS_EN       (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .rsv_en    (rsv_en),
    .rsv_idx   (rsv_idx),
    .rsv_stall (rsv_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    rsv_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int port, input logic [3:0] idx, input logic [31:0] data);
    wr_en[port]           = 1'b1;
    wr_idx[port*4 +: 4]   = idx;
    wr_data[port*32 +: 32] = data;
  endtask

  task automatic rsv(input logic [3:0] idx);
    rsv_en  = 1'b1;
    rsv_idx = idx;
  endtask

  task automatic rd(input logic [3:0] idx0, input logic [3:0] idx1);
    rd_idx = {idx1, idx0};
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = '0;
    wr_idx  = '0;
    wr_data = '0;
    rd_idx  = '0;
    rsv_en  = 1'b0;
    rsv_idx = '0;
    rd(4'd5, 4'd3);
    #12;
    check("reset_rd0", rd_data[31:0], 32'h0);
    check("reset_ready", {30'd0, rd_ready}, 32'h3);
    check("reset_stall", {31'd0, rsv_stall}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // write r5 and read it back through bypass, then from storage
    wr(0, 4'd5, 32'hDEADBEEF);
    rd(4'd5, 4'd0);
    #1;
    check("byp_r5_data", rd_data[31:0], 32'hDEADBEEF);
    check("byp_r5_ready", {31'd0, rd_ready[0]}, 32'h1);
    step();
    idle();
    #1;
    check("r5_data", rd_data[31:0], 32'hDEADBEEF);

    // both ports hit r3: port 1 wins
    wr(0, 4'd3, 32'h11);
    wr(1, 4'd3, 32'h22);
    rd(4'd5, 4'd3);
    #1;
    check("byp_r3_prio", rd_data[63:32], 32'h22);
    step();
    idle();
    #1;
    check("r3_prio", rd_data[63:32], 32'h22);

    // reserve r7, then write releases it
    rsv(4'd7);
    #1;
    check("rsv7_nostall", {31'd0, rsv_stall}, 32'h0);
    step();
    idle();
    rd(4'd7, 4'd3);
    #1;
    check("r7_pending", {31'd0, rd_ready[0]}, 32'h0);
    wr(1, 4'd7, 32'h5);
    #1;
    check("r7_byp_ready", {31'd0, rd_ready[0]}, 32'h1);
    check("r7_byp_data", rd_data[31:0], 32'h5);
    step();
    idle();
    #1;
    check("r7_released", {31'd0, rd_ready[0]}, 32'h1);
    check("r7_data", rd_data[31:0], 32'h5);

    // WAW stall, then reserve together with a write
    rsv(4'd7);
    step();
    #1;
    check("r7_waw_stall", {31'd0, rsv_stall}, 32'h1);
    check("r7_stall_pend", {31'd0, rd_ready[0]}, 32'h0);
    step();
    idle();
    #1;
    check("r7_still_pend", {31'd0, rd_ready[0]}, 32'h0);
    rsv(4'd7);
    wr(0, 4'd7, 32'h9);
    #1;
    check("r7_rsvwr_nostall", {31'd0, rsv_stall}, 32'h0);
    step();
    idle();
    #1;
    check("r7_rsvwr_pend", {31'd0, rd_ready[0]}, 32'h0);
    check("r7_rsvwr_data", rd_data[31:0], 32'h9);
    wr(0, 4'd7, 32'hA);
    step();
    idle();
    #1;
    check("r7_clear", {31'd0, rd_ready[0]}, 32'h1);

    // zero register
    wr(0, 4'd0, 32'hFF);
    rsv(4'd0);
    rd(4'd0, 4'd0);
    #1;
    check("r0_byp_data", rd_data[31:0], 32'h0);
    check("r0_stall", {31'd0, rsv_stall}, 32'h0);
    step();
    idle();
    #1;
    check("r0_data", rd_data[31:0], 32'h0);
    check("r0_ready", {31'd0, rd_ready[0]}, 32'h1);
    rsv(4'd0);
    #1;
    check("r0_rsv_again", {31'd0, rsv_stall}, 32'h0);
    step();
    idle();

    // mid-run reset with a pending register and stored data
    rsv(4'd9);
    step();
    idle();
    rd(4'd5, 4'd9);
    #1;
    check("r9_pending", {31'd0, rd_ready[1]}, 32'h0);
    check("r5_before_rst", rd_data[31:0], 32'hDEADBEEF);
    wr(0, 4'd5, 32'h1234);
    rst_n = 1'b0;
    #1;
    check("midrst_rd0", rd_data[31:0], 32'h0);
    check("midrst_rd1", rd_data[63:32], 32'h0);
    check("midrst_ready", {30'd0, rd_ready}, 32'h3);
    step();
    idle();
    rst_n = 1'b1;
    rd(4'd3, 4'd9);
    #1;
    check("after_rst_r3", rd_data[31:0], 32'h0);
    check("after_rst_r9", {31'd0, rd_ready[1]}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
